// File: rtl/cmp_pkg.sv
// Shared definitions for the digit compare path: one-hot result codes and FSM states.
package cmp_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_word_serial_if.sv
// Digit-in / word-out valid-ready bundle of the serial word comparator.
interface cmp_word_serial_if;

    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_res;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_res;
    logic       out_err;

    modport master (
        output in_valid, in_res, out_ready,
        input  in_ready, out_valid, out_res, out_err
    );

    modport slave (
        input  in_valid, in_res, out_ready,
        output in_ready, out_valid, out_res, out_err
    );

endinterface

// File: rtl/cmp_onehot_chk.sv
// Classifies one per-digit result code: legal one-hot, and whether it is EQ.
module cmp_onehot_chk
    import cmp_pkg::*;
(
    input  logic [2:0] res,
    output logic       legal,
    output logic       is_eq
);

    assign legal = (res == CMP_GT) || (res == CMP_EQ) || (res == CMP_LT);
    assign is_eq = (res == CMP_EQ);

endmodule

// File: rtl/cmp_word_serial.sv
// Resolves a wide-word compare from a stream of MSB-first per-digit results;
// the first non-EQ digit decides, and any illegal digit poisons the word.
module cmp_word_serial
    import cmp_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int CNT_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_clear,
    cmp_word_serial_if.slave         bus,
    output logic                     busy,
    output logic [7:0]               word_cnt
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;
    logic [2:0]        dec_q, dec_d;
    logic              err_q, err_d;
    logic [7:0]        word_cnt_q, word_cnt_d;

    logic legal, is_eq, accept;

    cmp_onehot_chk u_chk (
        .res   (bus.in_res),
        .legal (legal),
        .is_eq (is_eq)
    );

    assign accept = bus.in_valid && bus.in_ready;

    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        dec_d      = dec_q;
        err_d      = err_q;
        word_cnt_d = word_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dcnt_d  = CNT_W'(1);
                    dec_d   = legal ? bus.in_res : CMP_EQ;
                    err_d   = !legal;
                    state_d = (DIGITS == 1) ? S_HOLD : S_SCAN;
                end
            end
            S_SCAN: begin
                if (accept) begin
                    dcnt_d = dcnt_q + 1'b1;
                    if (dec_q == CMP_EQ && legal && !is_eq)
                        dec_d = bus.in_res;
                    if (!legal)
                        err_d = 1'b1;
                    if (dcnt_q == CNT_W'(DIGITS - 1))
                        state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d    = S_IDLE;
                    word_cnt_d = word_cnt_q + 8'd1;
                    dec_d      = CMP_EQ;
                    err_d      = 1'b0;
                    dcnt_d     = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats both a digit accept and the output handshake.
        if (in_clear) begin
            state_d    = S_IDLE;
            dcnt_d     = '0;
            dec_d      = CMP_EQ;
            err_d      = 1'b0;
            word_cnt_d = word_cnt_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dcnt_q     <= '0;
            dec_q      <= CMP_EQ;
            err_q      <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            dec_q      <= dec_d;
            err_q      <= err_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Outputs decode straight from registers, so nothing on the input side reaches them.
    assign bus.in_ready  = (state_q != S_HOLD);
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_err   = (state_q == S_HOLD) && err_q;
    assign bus.out_res   = (state_q == S_HOLD && !err_q) ? dec_q : 3'b000;
    assign busy          = (state_q != S_IDLE);
    assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_cmp_word_serial.sv
// Randomized and directed checks of cmp_word_serial against a word-level reference model.
module tb_cmp_word_serial;
    import cmp_pkg::*;

    localparam int DIGITS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_clear = 1'b0;
    logic       in_clear1 = 1'b0;
    logic       busy, busy1;
    logic [7:0] word_cnt, word_cnt1;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    cmp_word_serial_if bus ();
    cmp_word_serial_if bus1 ();

    cmp_word_serial #(.DIGITS(DIGITS), .CNT_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_clear (in_clear),
        .bus      (bus.slave),
        .busy     (busy),
        .word_cnt (word_cnt)
    );

    cmp_word_serial #(.DIGITS(1), .CNT_W(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_clear (in_clear1),
        .bus      (bus1.slave),
        .busy     (busy1),
        .word_cnt (word_cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word result from the rules: any illegal code -> {err,000}; else first non-EQ digit, else EQ.
    function automatic logic [3:0] model(input logic [2:0] d[$]);
        logic       err = 1'b0;
        logic       decided = 1'b0;
        logic [2:0] res = CMP_EQ;
        foreach (d[i]) begin
            if (!(d[i] == CMP_GT || d[i] == CMP_EQ || d[i] == CMP_LT))
                err = 1'b1;
            else if (!decided && d[i] != CMP_EQ) begin
                res = d[i];
                decided = 1'b1;
            end
        end
        return err ? 4'b1000 : {1'b0, res};
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_digit(input logic [2:0] d, input int gap);
        bit done = 0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_res   = d;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin
                @(posedge clk); #1;
                done = 1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic run_word(input logic [2:0] d[$], input int max_gap, input int hold);
        logic [3:0] exp = model(d);
        foreach (d[i]) begin
            send_digit(d[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            if (i < d.size() - 1) begin
                check("scan_out_valid", bus.out_valid, 0);
                check("scan_busy", busy, 1);
            end
        end
        check("hold_out_valid", bus.out_valid, 1);
        check("hold_out_res", bus.out_res, exp[2:0]);
        check("hold_out_err", bus.out_err, exp[3]);
        check("hold_in_ready", bus.in_ready, 0);
        repeat (hold) begin
            @(posedge clk); #1;
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_out_res", bus.out_res, exp[2:0]);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_word_cnt", word_cnt, exp_cnt[7:0]);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        check("done_out_valid", bus.out_valid, 0);
        check("done_word_cnt", word_cnt, exp_cnt[7:0]);
        check("done_busy", busy, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_res"}, bus.out_res, 0);
        check({tag, "_out_err"}, bus.out_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_word_cnt"}, word_cnt, 0);
        check({tag, "_in_ready"}, bus.in_ready, 1);
    endtask

    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_vals(tag);
        exp_cnt = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [2:0] w[$];
        logic [2:0] d;

        bus.in_valid = 0; bus.in_res = 0; bus.out_ready = 0;
        bus1.in_valid = 0; bus1.in_res = 0; bus1.out_ready = 0;

        repeat (2) @(posedge clk);
        #1 check_reset_vals("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("release");

        // First non-EQ digit decides
        w = '{CMP_EQ, CMP_EQ, CMP_GT, CMP_LT};
        run_word(w, 0, 0);
        w = '{CMP_EQ, CMP_EQ, CMP_EQ, CMP_EQ};
        run_word(w, 0, 0);
        w = '{CMP_LT, CMP_GT, CMP_GT, CMP_GT};
        run_word(w, 0, 0);

        // Illegal code poisons only its own word
        w = '{CMP_EQ, 3'b011, CMP_GT, CMP_EQ};
        run_word(w, 0, 0);
        w = '{CMP_GT, CMP_EQ, CMP_EQ, CMP_EQ};
        run_word(w, 0, 0);
        w = '{3'b000, CMP_EQ, CMP_EQ, CMP_EQ};
        run_word(w, 0, 0);

        // Input gaps and a stalled consumer
        w = '{CMP_EQ, CMP_LT, CMP_EQ, CMP_GT};
        run_word(w, 3, 5);

        // Abort after two digits; the digit offered with the abort is dropped
        send_digit(CMP_GT, 0);
        send_digit(CMP_EQ, 0);
        in_clear = 1'b1; bus.in_valid = 1'b1; bus.in_res = CMP_GT;
        @(posedge clk); #1;
        in_clear = 1'b0; bus.in_valid = 1'b0;
        check("clear_busy", busy, 0);
        check("clear_out_valid", bus.out_valid, 0);
        check("clear_word_cnt", word_cnt, exp_cnt[7:0]);
        w = '{CMP_LT, CMP_EQ, CMP_EQ, CMP_EQ};
        run_word(w, 0, 0);

        // Abort wins over a same-cycle output handshake
        for (int i = 0; i < DIGITS; i++) send_digit(CMP_GT, 0);
        check("clr_hold_out_valid", bus.out_valid, 1);
        in_clear = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        in_clear = 1'b0; bus.out_ready = 1'b0;
        check("clr_hs_out_valid", bus.out_valid, 0);
        check("clr_hs_word_cnt", word_cnt, exp_cnt[7:0]);

        // Single-digit build
        bus1.in_valid = 1'b1; bus1.in_res = CMP_GT;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        check("d1_out_valid", bus1.out_valid, 1);
        check("d1_out_res", bus1.out_res, CMP_GT);
        check("d1_busy", busy1, 1);
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        check("d1_word_cnt", word_cnt1, 1);
        check("d1_done_valid", bus1.out_valid, 0);

        // Reset mid-scan and in hold
        send_digit(CMP_EQ, 0);
        send_digit(CMP_LT, 0);
        mid_reset("rst_scan");
        w = '{CMP_EQ, CMP_EQ, CMP_EQ, CMP_GT};
        run_word(w, 0, 0);
        for (int i = 0; i < DIGITS; i++) send_digit(CMP_LT, 0);
        check("rst_hold_pre_valid", bus.out_valid, 1);
        mid_reset("rst_hold");

        // Randomized words
        repeat (60) begin
            w.delete();
            for (int k = 0; k < DIGITS; k++) begin
                if ($urandom_range(0, 3) == 0) d = 3'($urandom_range(0, 7));
                else d = 3'(1 << $urandom_range(0, 2));
                w.push_back(d);
            end
            run_word(w, 2, int'($urandom_range(0, 3)));
        end

        // Word counter wraps through 255 -> 0
        w = '{CMP_EQ, CMP_EQ, CMP_EQ, CMP_EQ};
        repeat (256) run_word(w, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
